// File: rtl/controls_pkg.sv
// Shared types and constants for the front-panel button conditioner.
package controls_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RPT
    } rpt_state_t;

    localparam int DEF_N_CH            = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 32;
    localparam int DEF_REPEAT_RATE     = 8;
    localparam int DEF_MAX_ACTIVE      = 1;
    localparam int DEF_START_DELAY     = 2;

    // Bit positions within the select vector for the default channel map.
    localparam int SEL_MOVE     = 0;
    localparam int SEL_AIM      = 1;
    localparam int SEL_SHOOT    = 2;
    localparam int SEL_NEW_GAME = DEF_N_CH;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button lane: 2-FF synchroniser, debounce, rise detect and hold-to-repeat FSM.
module button_channel
    import controls_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic repeat_en,
    input  logic conflict,
    output logic held,
    output logic pq
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LOAD = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LOAD = RW'(REPEAT_RATE - 1);

    logic          s1, s2;
    logic [DW-1:0] cnt, cnt_nxt;
    logic          held_nxt, rise, fall;
    rpt_state_t    state, state_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic          conflict_q, tick;

    always_comb begin
        held_nxt = held;
        cnt_nxt  = cnt;
        if (s2 == held) begin
            cnt_nxt = '0;
        end else if (cnt == DB_LAST) begin
            held_nxt = s2;
            cnt_nxt  = '0;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    assign rise = held_nxt & ~held;
    assign fall = ~held_nxt & held;

    // A tick coinciding with release is suppressed so no pulse trails the fall.
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        tick      = 1'b0;
        if (fall || !repeat_en || conflict) begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise || (held && conflict_q)) begin
                        state_nxt = WAIT;
                        rcnt_nxt  = RD_LOAD;
                    end
                end
                WAIT, RPT: begin
                    if (rcnt == '0) begin
                        tick      = 1'b1;
                        state_nxt = RPT;
                        rcnt_nxt  = RR_LOAD;
                    end else begin
                        rcnt_nxt = rcnt - 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    rcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            cnt        <= '0;
            held       <= 1'b0;
            pq         <= 1'b0;
            state      <= IDLE;
            rcnt       <= '0;
            conflict_q <= 1'b0;
        end else begin
            s1         <= btn;
            s2         <= s1;
            cnt        <= cnt_nxt;
            held       <= held_nxt;
            pq         <= rise | tick;
            state      <= state_nxt;
            rcnt       <= rcnt_nxt;
            conflict_q <= conflict;
        end
    end

endmodule

// File: rtl/button_arbiter.sv
// Front-panel conditioner: per-channel debounce/repeat, conflict suppression,
// delayed new-game pulse and one-hot live-action select.
module button_arbiter
    import controls_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int MAX_ACTIVE      = DEF_MAX_ACTIVE,
    parameter int START_DELAY     = DEF_START_DELAY
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] repeat_en,
    input  logic            start_in,
    output logic [N_CH-1:0] held,
    output logic [N_CH-1:0] pulse_out,
    output logic            conflict,
    output logic            start_pulse,
    output logic [N_CH:0]   select
);

    localparam int PCW = $clog2(N_CH + 1);

    logic [N_CH-1:0]    pq;
    logic [PCW-1:0]     active_cnt;
    logic [START_DELAY:0] start_sr;
    logic               start_q;
    logic               found;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .btn      (btn_in[g]),
            .repeat_en(repeat_en[g]),
            .conflict (conflict),
            .held     (held[g]),
            .pq       (pq[g])
        );
    end

    always_comb begin
        active_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            active_cnt = active_cnt + PCW'(held[i]);
        end
    end

    assign conflict  = (int'(active_cnt) > MAX_ACTIVE);
    assign pulse_out = pq & ~{N_CH{conflict}};

    // Extra stage beyond START_DELAY holds the previous value for rise detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            start_sr <= '0;
            start_q  <= 1'b0;
        end else begin
            start_sr <= {start_sr[START_DELAY-1:0], start_in};
            start_q  <= start_sr[START_DELAY-1] & ~start_sr[START_DELAY];
        end
    end

    assign start_pulse = start_q & ~(|held);

    always_comb begin
        select = '0;
        found  = 1'b0;
        if (!conflict) begin
            for (int i = 0; i < N_CH; i++) begin
                if (held[i] && !found) begin
                    select[i] = 1'b1;
                    found     = 1'b1;
                end
            end
            if (!found && start_pulse) begin
                select[N_CH] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_button_arbiter.sv
// Bench for button_arbiter: directed literal scenarios plus randomized stimulus
// checked every cycle against a behavioural model.
module tb_button_arbiter;

    localparam int N  = 5;
    localparam int D  = 4;
    localparam int RD = 32;
    localparam int RR = 8;
    localparam int MA = 1;
    localparam int SD = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] repeat_en = '0;
    logic         start_in = 1'b0;
    logic [N-1:0] held, pulse_out;
    logic         conflict, start_pulse;
    logic [N:0]   select;

    always #5 clk = ~clk;

    button_arbiter #(
        .N_CH(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR), .MAX_ACTIVE(MA), .START_DELAY(SD)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .repeat_en(repeat_en),
        .start_in(start_in), .held(held), .pulse_out(pulse_out),
        .conflict(conflict), .start_pulse(start_pulse), .select(select)
    );

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pop(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    // Behavioural model state.
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_held = '0, m_pq = '0;
    int           m_streak[N];
    int           m_due[N];
    logic         m_conf_prev = 1'b0;
    logic [SD:0]  m_hist = '0;
    logic         m_start_q = 1'b0;
    int           ecount = 0;

    always @(posedge clk) begin : model
        logic [N-1:0] hn;
        logic conf_now, rise, fall, tick;
        ecount++;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_held = '0; m_pq = '0;
            m_conf_prev = 1'b0; m_hist = '0; m_start_q = 1'b0;
            for (int i = 0; i < N; i++) begin m_streak[i] = 0; m_due[i] = -1; end
        end else begin
            conf_now = pop(m_held) > MA;
            hn = m_held;
            for (int i = 0; i < N; i++) begin
                // level flips once the synchronised input has disagreed for D samples
                if (m_s2[i] == m_held[i]) m_streak[i] = 0;
                else begin
                    m_streak[i]++;
                    if (m_streak[i] == D) begin hn[i] = m_s2[i]; m_streak[i] = 0; end
                end
                rise = hn[i] & ~m_held[i];
                fall = ~hn[i] & m_held[i];
                tick = (m_due[i] == ecount) && !fall && repeat_en[i] && !conf_now;
                if (fall || !repeat_en[i] || conf_now) m_due[i] = -1;
                else if (m_due[i] < 0 && (rise || (m_held[i] && m_conf_prev))) m_due[i] = ecount + RD;
                else if (tick) m_due[i] = ecount + RR;
                m_pq[i] = rise | tick;
            end
            m_conf_prev = conf_now;
            m_held = hn;
            m_s2 = m_s1;
            m_s1 = btn_in;
            m_start_q = m_hist[SD-1] & ~m_hist[SD];
            m_hist = {m_hist[SD-1:0], start_in};
        end
    end

    always @(negedge clk) begin : compare
        logic         e_conf, e_start;
        logic [N-1:0] e_pulse;
        logic [N:0]   e_sel;
        if (chk_on) begin
            e_conf  = pop(m_held) > MA;
            e_pulse = e_conf ? '0 : m_pq;
            e_start = m_start_q && (m_held == '0);
            e_sel   = '0;
            if (!e_conf) begin
                if (m_held != '0) begin
                    for (int i = N - 1; i >= 0; i--) if (m_held[i]) begin e_sel = '0; e_sel[i] = 1'b1; end
                end else if (e_start) e_sel[N] = 1'b1;
            end
            check("m_held", 32'(held), 32'(m_held));
            check("m_pulse", 32'(pulse_out), 32'(e_pulse));
            check("m_conflict", 32'(conflict), 32'(e_conf));
            check("m_start", 32'(start_pulse), 32'(e_start));
            check("m_select", 32'(select), 32'(e_sel));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        int cnt, lowp;
        int pt[$];
        cyc(3);
        check("rst_held", 32'(held), 32'h0);
        check("rst_pulse", 32'(pulse_out), 32'h0);
        check("rst_misc", 32'({conflict, start_pulse, select}), 32'h0);
        chk_on = 1'b1;
        reset = 1'b1;
        cyc(3);

        // single press on channel 2
        btn_in[2] = 1'b1;
        cyc(5);
        check("press_early", 32'(held), 32'h0);
        cyc(1);
        check("press_held", 32'(held), 32'b00100);
        check("press_pulse", 32'(pulse_out), 32'b00100);
        check("press_sel", 32'(select), 32'b000100);
        cyc(1);
        check("press_one", 32'(pulse_out), 32'h0);
        cyc(13);
        btn_in[2] = 1'b0;
        cyc(5);
        check("rel_late", 32'(held[2]), 32'h1);
        cyc(1);
        check("rel_fall", 32'(held[2]), 32'h0);
        cyc(5);

        // 3-cycle glitch on channel 0
        btn_in[0] = 1'b1;
        cyc(3);
        btn_in[0] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (held != '0 || pulse_out != '0 || select != '0) cnt++;
        end
        check("glitch", 32'(cnt), 32'h0);

        // hold-to-repeat on channel 1
        repeat_en[1] = 1'b1;
        btn_in[1] = 1'b1;
        lowp = 0;
        for (int k = 0; k < 100; k++) begin
            if (k == 80) btn_in[1] = 1'b0;
            @(negedge clk);
            if (pulse_out[1]) begin
                pt.push_back(k);
                if (!held[1]) lowp++;
            end
        end
        check("rpt_count", 32'(pt.size()), 32'd7);
        check("rpt_after_fall", 32'(lowp), 32'h0);
        if (pt.size() >= 3) begin
            check("rpt_first", 32'(pt[0]), 32'd5);
            check("rpt_delay", 32'(pt[1] - pt[0]), 32'd32);
            check("rpt_rate", 32'(pt[2] - pt[1]), 32'd8);
        end
        repeat_en[1] = 1'b0;
        cyc(5);

        // simultaneous press on channels 0 and 3
        btn_in[0] = 1'b1;
        btn_in[3] = 1'b1;
        cyc(6);
        check("conf_held", 32'(held), 32'b01001);
        check("conf_flag", 32'(conflict), 32'h1);
        check("conf_pulse", 32'(pulse_out), 32'h0);
        check("conf_sel", 32'(select), 32'h0);
        cyc(4);
        btn_in[3] = 1'b0;
        cyc(6);
        check("conf_drop", 32'(conflict), 32'h0);
        check("conf_sel0", 32'(select), 32'b000001);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (pulse_out != '0) cnt++;
        end
        check("conf_nopulse", 32'(cnt), 32'h0);
        btn_in[0] = 1'b0;
        cyc(10);

        // new-game pulse
        start_in = 1'b1;
        cyc(2);
        check("start_early", 32'(start_pulse), 32'h0);
        cyc(1);
        check("start_pulse", 32'(start_pulse), 32'h1);
        check("start_sel", 32'(select), 32'b100000);
        cyc(1);
        check("start_one", 32'(start_pulse), 32'h0);
        start_in = 1'b0;
        cyc(5);
        btn_in[4] = 1'b1;
        cyc(10);
        start_in = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (start_pulse) cnt++;
        end
        check("start_blocked", 32'(cnt), 32'h0);
        start_in = 1'b0;
        btn_in[4] = 1'b0;
        cyc(10);

        // reset in the middle of a hold
        btn_in[1] = 1'b1;
        cyc(12);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_mid", 32'({held, pulse_out, conflict, start_pulse, select}), 32'h0);
        end
        reset = 1'b1;
        cyc(5);
        check("rst_rearm_early", 32'(held), 32'h0);
        cyc(1);
        check("rst_rearm_pulse", 32'(pulse_out), 32'b00010);
        btn_in[1] = 1'b0;
        cyc(10);

        // randomized traffic
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (btn_in[i]) begin
                    if ($urandom_range(0, 39) == 0) btn_in[i] = 1'b0;
                end else if ($urandom_range(0, 79) == 0) btn_in[i] = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) btn_in[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 299) == 0) repeat_en = N'($urandom);
            if ($urandom_range(0, 19) == 0) start_in = ~start_in;
            reset = ($urandom_range(0, 399) != 0);
        end
        reset = 1'b1;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
